// File: rtl/peripheral_dbg_soc_osd_event_arbiter_pkg.sv
// rtl/peripheral_dbg_soc_osd_event_arbiter_pkg.sv - shared types for the OSD event arbiter
package peripheral_dbg_soc_osd_event_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Grant index width; a single source still needs one bit.
  function automatic int grant_width(input int num_sources);
    return (num_sources > 1) ? $clog2(num_sources) : 1;
  endfunction

endpackage

// File: rtl/peripheral_dbg_soc_osd_rr_select.sv
// rtl/peripheral_dbg_soc_osd_rr_select.sv - combinational round-robin picker
// Returns the first set request at or above i_ptr, wrapping around.
module peripheral_dbg_soc_osd_rr_select
  import peripheral_dbg_soc_osd_event_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = grant_width(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_valid,
  output logic [W-1:0] o_idx
);

  int w_cand;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/peripheral_dbg_soc_osd_event_arbiter.sv
// rtl/peripheral_dbg_soc_osd_event_arbiter.sv - round-robin share of one event packetizer
// Optional per-source grant counters: OSD_EVENT_ARB_STATS_EN.
module peripheral_dbg_soc_osd_event_arbiter
  import peripheral_dbg_soc_osd_event_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES        = 4,
  parameter int MAX_DATA_NUM_WORDS = 8,
  localparam int NW = $clog2(MAX_DATA_NUM_WORDS + 1),
  localparam int IW = $clog2(MAX_DATA_NUM_WORDS),
  localparam int GW = grant_width(NUM_SOURCES)
) (
`ifdef OSD_EVENT_ARB_STATS_EN
  input  logic                             i_stats_clear,
  output logic [NUM_SOURCES-1:0][15:0]     o_grant_count,
`endif
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_SOURCES-1:0]           i_src_event_available,
  input  logic [NUM_SOURCES-1:0]           i_src_overflow,
  input  logic [NUM_SOURCES-1:0][NW-1:0]   i_src_data_num_words,
  input  logic [NUM_SOURCES-1:0][15:0]     i_src_data,
  output logic [IW-1:0]                    o_src_data_req_idx,
  output logic [NUM_SOURCES-1:0]           o_src_data_req_valid,
  output logic [NUM_SOURCES-1:0]           o_src_event_consumed,
  output logic                             o_pkt_event_available,
  output logic                             o_pkt_overflow,
  output logic [NW-1:0]                    o_pkt_data_num_words,
  output logic [15:0]                      o_pkt_data,
  input  logic [IW-1:0]                    i_pkt_data_req_idx,
  input  logic                             i_pkt_data_req_valid,
  input  logic                             i_pkt_event_consumed,
  output logic [GW-1:0]                    o_grant_idx
);

  arb_state_e    r_state;
  arb_state_e    w_next_state;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] r_grant_idx;
  logic [GW-1:0] w_ptr_next;
  logic          w_sel_valid;
  logic [GW-1:0] w_sel_idx;

  peripheral_dbg_soc_osd_rr_select #(
    .N(NUM_SOURCES),
    .W(GW)
  ) u_rr_select (
    .i_req  (i_src_event_available),
    .i_ptr  (r_rr_ptr),
    .o_valid(w_sel_valid),
    .o_idx  (w_sel_idx)
  );

  assign w_ptr_next  = (r_grant_idx == GW'(NUM_SOURCES - 1)) ? '0 : r_grant_idx + 1'b1;
  assign o_grant_idx = r_grant_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_sel_valid) r_grant_idx <= w_sel_idx;
      if (r_state == BUSY && i_pkt_event_consumed) r_rr_ptr <= w_ptr_next;
    end
  end

  // The lock is released only by the packetizer's consume, even if the source drops its request.
  always_comb begin
    w_next_state          = r_state;
    o_pkt_event_available = 1'b0;
    o_pkt_overflow        = 1'b0;
    o_pkt_data_num_words  = '0;
    o_pkt_data            = '0;
    o_src_data_req_valid  = '0;
    o_src_event_consumed  = '0;
    o_src_data_req_idx    = i_pkt_data_req_idx;
    case (r_state)
      IDLE: begin
        if (w_sel_valid) w_next_state = BUSY;
      end
      BUSY: begin
        o_pkt_event_available = i_src_event_available[r_grant_idx];
        o_pkt_overflow        = i_src_overflow[r_grant_idx];
        o_pkt_data_num_words  = i_src_data_num_words[r_grant_idx];
        o_pkt_data            = i_src_data[r_grant_idx];
        o_src_data_req_valid[r_grant_idx] = i_pkt_data_req_valid;
        o_src_event_consumed[r_grant_idx] = i_pkt_event_consumed;
        if (i_pkt_event_consumed) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

`ifdef OSD_EVENT_ARB_STATS_EN
  logic [NUM_SOURCES-1:0][15:0] r_grant_count;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (i_rst || i_stats_clear) begin
        r_grant_count[i] <= '0;
      end else if (o_src_event_consumed[i] && r_grant_count[i] != 16'hFFFF) begin
        r_grant_count[i] <= r_grant_count[i] + 16'd1;
      end
    end
  end

  assign o_grant_count = r_grant_count;
`endif

endmodule

// File: tb/tb_peripheral_dbg_soc_osd_event_arbiter.sv
// tb/tb_peripheral_dbg_soc_osd_event_arbiter.sv - directed bench for the OSD event arbiter
module tb_peripheral_dbg_soc_osd_event_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       avail;
  logic [3:0]       ovf;
  logic [3:0][3:0]  nw;
  logic [3:0][15:0] src_data;
  logic [3:0][15:0] base;
  logic [2:0]       src_idx;
  logic [3:0]       src_rv;
  logic [3:0]       src_cons;
  logic             pkt_avail;
  logic             pkt_ovf;
  logic [3:0]       pkt_nw;
  logic [15:0]      pkt_data;
  logic [2:0]       pkt_idx;
  logic             pkt_rv;
  logic             pkt_cons;
  logic [1:0]       grant;
`ifdef OSD_EVENT_ARB_STATS_EN
  logic             stats_clear;
  logic [3:0][15:0] grant_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Source model: each word is the source's base value plus the requested index.
  always_comb begin
    for (int i = 0; i < 4; i++) src_data[i] = base[i] + {13'd0, src_idx};
  end

  peripheral_dbg_soc_osd_event_arbiter #(
    .NUM_SOURCES(4),
    .MAX_DATA_NUM_WORDS(8)
  ) dut (
`ifdef OSD_EVENT_ARB_STATS_EN
    .i_stats_clear        (stats_clear),
    .o_grant_count        (grant_count),
`endif
    .i_clk                (clk),
    .i_rst                (rst),
    .i_src_event_available(avail),
    .i_src_overflow       (ovf),
    .i_src_data_num_words (nw),
    .i_src_data           (src_data),
    .o_src_data_req_idx   (src_idx),
    .o_src_data_req_valid (src_rv),
    .o_src_event_consumed (src_cons),
    .o_pkt_event_available(pkt_avail),
    .o_pkt_overflow       (pkt_ovf),
    .o_pkt_data_num_words (pkt_nw),
    .o_pkt_data           (pkt_data),
    .i_pkt_data_req_idx   (pkt_idx),
    .i_pkt_data_req_valid (pkt_rv),
    .i_pkt_event_consumed (pkt_cons),
    .o_grant_idx          (grant)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; avail = '0; ovf = '0; nw = '0; pkt_idx = '0; pkt_rv = 1'b0; pkt_cons = 1'b0;
    for (int i = 0; i < 4; i++) base[i] = 16'h1000 * (i + 1);
`ifdef OSD_EVENT_ARB_STATS_EN
    stats_clear = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("rst_pkt_avail", pkt_avail, 0);
    check_eq("rst_pkt_ovf", pkt_ovf, 0);
    check_eq("rst_pkt_data", pkt_data, 0);
    check_eq("rst_pkt_nw", pkt_nw, 0);
    check_eq("rst_src_rv", src_rv, 0);
    check_eq("rst_src_cons", src_cons, 0);
    check_eq("rst_grant", grant, 0);

    // Single request from source 2, three words
    avail = 4'b0100; nw[2] = 4'd3;
    #1 check_eq("t1_pre_grant_avail", pkt_avail, 0);
    tick();
    check_eq("t1_grant", grant, 2);
    check_eq("t1_pkt_avail", pkt_avail, 1);
    check_eq("t1_pkt_nw", pkt_nw, 3);
    for (int k = 0; k < 3; k++) begin
      pkt_rv = 1'b1; pkt_idx = 3'(k);
      #1;
      check_eq("t1_src_rv", src_rv, 4'b0100);
      check_eq("t1_src_idx", src_idx, k);
      check_eq("t1_pkt_data", pkt_data, 16'h3000 + k);
    end
    pkt_rv = 1'b0; pkt_cons = 1'b1;
    #1 check_eq("t1_src_cons", src_cons, 4'b0100);
    tick();
    pkt_cons = 1'b0; avail = '0;
    #1 check_eq("t1_after_avail", pkt_avail, 0);

    // Consume while IDLE is ignored
    pkt_cons = 1'b1;
    #1 check_eq("idle_cons_ignored", src_cons, 0);
    tick();
    pkt_cons = 1'b0;
    #1 check_eq("idle_cons_no_grant", pkt_avail, 0);

    // Fairness with all sources requesting
    rst = 1'b1; tick(); rst = 1'b0;
    avail = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("rr_grant", grant, k % 4);
      check_eq("rr_busy_avail", pkt_avail, 1);
      pkt_cons = 1'b1;
      #1 check_eq("rr_src_cons", src_cons, 4'b0001 << (k % 4));
      tick();
      pkt_cons = 1'b0;
      #1 check_eq("rr_idle_gap", pkt_avail, 0);
    end
    avail = '0;

    // Overflow forwarding from source 1
    avail = 4'b0010; ovf[1] = 1'b1; base[1] = 16'h0007;
    tick();
    pkt_rv = 1'b1; pkt_idx = '0;
    #1;
    check_eq("ovf_grant", grant, 1);
    check_eq("ovf_pkt_ovf", pkt_ovf, 1);
    check_eq("ovf_pkt_data", pkt_data, 16'h0007);
    check_eq("ovf_src_rv", src_rv, 4'b0010);
    pkt_rv = 1'b0; pkt_cons = 1'b1;
    tick();
    pkt_cons = 1'b0; avail = '0; ovf = '0; base[1] = 16'h2000;
    #1;
    check_eq("ovf_idle_ovf", pkt_ovf, 0);
    check_eq("ovf_idle_data", pkt_data, 0);

    // Source 3 drops its request mid-event
    avail = 4'b1000; nw[3] = 4'd5;
    tick();
    check_eq("drop_grant", grant, 3);
    avail = '0;
    tick();
    pkt_rv = 1'b1;
    #1;
    check_eq("drop_src_rv", src_rv, 4'b1000);
    check_eq("drop_pkt_nw", pkt_nw, 5);
    check_eq("drop_pkt_avail", pkt_avail, 0);
    pkt_rv = 1'b0; pkt_cons = 1'b1;
    #1 check_eq("drop_src_cons", src_cons, 4'b1000);
    tick();
    pkt_cons = 1'b0; avail = 4'hF;
    tick();
    check_eq("drop_rr_wrap", grant, 0);
    pkt_cons = 1'b1;
    tick();
    pkt_cons = 1'b0; avail = 4'b0100;

    // Reset while granted to source 2
    tick();
    check_eq("rstmid_grant", grant, 2);
    pkt_rv = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("rstmid_pkt_avail", pkt_avail, 0);
    check_eq("rstmid_src_rv", src_rv, 0);
    check_eq("rstmid_pkt_data", pkt_data, 0);
    check_eq("rstmid_pkt_nw", pkt_nw, 0);
    check_eq("rstmid_grant_idx", grant, 0);
    pkt_rv = 1'b0; avail = 4'hF;
    tick();
    check_eq("rstmid_first_grant", grant, 0);
    pkt_cons = 1'b1;
    tick();
    pkt_cons = 1'b0; avail = '0;

`ifdef OSD_EVENT_ARB_STATS_EN
    rst = 1'b1; tick(); rst = 1'b0;
    avail = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      pkt_cons = 1'b1;
      tick();
      pkt_cons = 1'b0;
    end
    avail = '0;
    #1 check_eq("stats_count3", grant_count[0], 3);
    force dut.r_grant_count[0] = 16'hFFFF;
    #1 release dut.r_grant_count[0];
    avail = 4'b0001;
    tick();
    pkt_cons = 1'b1;
    tick();
    pkt_cons = 1'b0; avail = '0;
    #1 check_eq("stats_saturate", grant_count[0], 16'hFFFF);
    avail = 4'b0001;
    tick();
    pkt_cons = 1'b1; stats_clear = 1'b1;
    tick();
    pkt_cons = 1'b0; stats_clear = 1'b0; avail = '0;
    #1 check_eq("stats_clear_wins", grant_count[0], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
